// File: rtl/bp_check_queue.sv
// In-flight branch prediction queue: records predictions at fetch, checks them in order
// at execute, and produces BHT update and mispredict-redirect pulses one cycle later.
module bp_check_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_pc,
    input  logic                     enq_pred_taken,
    input  logic [31:0]              enq_pred_pc,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [31:0]              res_target,
    output logic                     mispredict,
    output logic [31:0]              redirect_pc,
    output logic                     bht_is_write,
    output logic [31:0]              bht_executed_pc,
    output logic [31:0]              bht_dest_pc,
    output logic                     bht_is_taken,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0] pc_mem   [DEPTH];
    logic        pt_mem   [DEPTH];
    logic [31:0] ppc_mem  [DEPTH];

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;

    logic        mispredict_reg, mispredict_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;
    logic        bht_is_write_reg, bht_is_write_next;
    logic [31:0] bht_executed_pc_reg, bht_executed_pc_next;
    logic [31:0] bht_dest_pc_reg, bht_dest_pc_next;
    logic        bht_is_taken_reg, bht_is_taken_next;
    logic        underflow_reg, underflow_next;

    logic        enq_fire;
    logic        res_fire;
    logic        wrong;
    logic        res_wrong;
    logic        ram_we;
    logic [31:0] head_pc;
    logic        head_pt;
    logic [31:0] head_ppc;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign enq_ready = (count_reg != FULL);
    assign enq_fire  = enq_valid && enq_ready;
    assign res_fire  = res_valid && (count_reg != '0);

    assign head_pc  = pc_mem[head_reg];
    assign head_pt  = pt_mem[head_reg];
    assign head_ppc = ppc_mem[head_reg];

    assign wrong     = (head_pt != res_taken) || (res_taken && (head_ppc != res_target));
    assign res_wrong = res_fire && wrong;
    assign ram_we    = enq_fire && !res_wrong && !flush && !reset;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            pc_mem[tail_reg]  <= enq_pc;
            pt_mem[tail_reg]  <= enq_pred_taken;
            ppc_mem[tail_reg] <= enq_pred_pc;
        end
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush || res_wrong) begin
            // A mispredict squashes every younger entry along with any incoming one.
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (res_fire) begin
                head_next = head_reg + 1'b1;
            end
            if (enq_fire) begin
                tail_next = tail_reg + 1'b1;
            end
            case ({enq_fire, res_fire})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_comb begin
        mispredict_next      = 1'b0;
        redirect_pc_next     = '0;
        bht_is_write_next    = 1'b0;
        bht_executed_pc_next = '0;
        bht_dest_pc_next     = '0;
        bht_is_taken_next    = 1'b0;
        underflow_next       = 1'b0;
        if (!flush) begin
            if (res_valid && (count_reg == '0)) begin
                underflow_next = 1'b1;
            end
            if (res_fire) begin
                bht_is_write_next    = 1'b1;
                bht_executed_pc_next = head_pc;
                bht_dest_pc_next     = res_target;
                bht_is_taken_next    = res_taken;
                if (wrong) begin
                    mispredict_next  = 1'b1;
                    // Not-taken fall-through skips the delay slot.
                    redirect_pc_next = res_taken ? res_target : (head_pc + 32'd8);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg            <= '0;
            tail_reg            <= '0;
            count_reg           <= '0;
            mispredict_reg      <= 1'b0;
            redirect_pc_reg     <= '0;
            bht_is_write_reg    <= 1'b0;
            bht_executed_pc_reg <= '0;
            bht_dest_pc_reg     <= '0;
            bht_is_taken_reg    <= 1'b0;
            underflow_reg       <= 1'b0;
        end else begin
            head_reg            <= head_next;
            tail_reg            <= tail_next;
            count_reg           <= count_next;
            mispredict_reg      <= mispredict_next;
            redirect_pc_reg     <= redirect_pc_next;
            bht_is_write_reg    <= bht_is_write_next;
            bht_executed_pc_reg <= bht_executed_pc_next;
            bht_dest_pc_reg     <= bht_dest_pc_next;
            bht_is_taken_reg    <= bht_is_taken_next;
            underflow_reg       <= underflow_next;
        end
    end

    assign mispredict      = mispredict_reg;
    assign redirect_pc     = redirect_pc_reg;
    assign bht_is_write    = bht_is_write_reg;
    assign bht_executed_pc = bht_executed_pc_reg;
    assign bht_dest_pc     = bht_dest_pc_reg;
    assign bht_is_taken    = bht_is_taken_reg;
    assign count           = count_reg;
    assign underflow       = underflow_reg;

endmodule

// File: tb/tb_bp_check_queue.sv
// Bench for bp_check_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bp_check_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ppc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_pc = '0;
    logic        enq_pred_taken = 1'b0;
    logic [31:0] enq_pred_pc = '0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        bht_is_write;
    logic [31:0] bht_executed_pc;
    logic [31:0] bht_dest_pc;
    logic        bht_is_taken;
    logic [$clog2(DEPTH):0] count;
    logic        underflow;

    bp_check_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
        .enq_pred_taken(enq_pred_taken), .enq_pred_pc(enq_pred_pc),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .bht_is_write(bht_is_write), .bht_executed_pc(bht_executed_pc),
        .bht_dest_pc(bht_dest_pc), .bht_is_taken(bht_is_taken),
        .count(count), .underflow(underflow)
    );

    always #5 clk = ~clk;

    ent_t q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   known = 0;
    bit   verbose = 1;

    logic        e_mis, e_bw, e_btk, e_und;
    logic [31:0] e_red, e_bpc, e_bdst, e_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: an in-order list of predictions; resolution compares against the oldest.
    task automatic model_step(input logic r, f, ev, input logic [31:0] epc, input logic ept,
                              input logic [31:0] eppc, input logic rv, rt, input logic [31:0] rtg);
        logic acc;
        ent_t h, n;
        e_mis = 0; e_red = 0; e_bw = 0; e_bpc = 0; e_bdst = 0; e_btk = 0; e_und = 0;
        if (r || f) begin
            q.delete();
        end else begin
            acc = ev && (q.size() != DEPTH);
            if (rv) begin
                if (q.size() == 0) begin
                    e_und = 1;
                end else begin
                    h = q.pop_front();
                    e_bw = 1; e_bpc = h.pc; e_bdst = rtg; e_btk = rt;
                    if ((h.pt != rt) || (rt && h.ppc != rtg)) begin
                        e_mis = 1;
                        e_red = rt ? rtg : h.pc + 32'd8;
                        q.delete();
                        acc = 0;
                    end
                end
            end
            if (acc) begin
                n.pc = epc; n.pt = ept; n.ppc = eppc;
                q.push_back(n);
            end
        end
        e_cnt = 32'(q.size());
    endtask

    task automatic cyc(input logic r, f, ev, input logic [31:0] epc, input logic ept,
                       input logic [31:0] eppc, input logic rv, rt, input logic [31:0] rtg);
        reset = r; flush = f; enq_valid = ev; enq_pc = epc; enq_pred_taken = ept;
        enq_pred_pc = eppc; res_valid = rv; res_taken = rt; res_target = rtg;
        if (known) chk("enq_ready", 32'(enq_ready), 32'(q.size() != DEPTH));
        model_step(r, f, ev, epc, ept, eppc, rv, rt, rtg);
        @(posedge clk);
        #1;
        known = 1;
        chk("mispredict",      32'(mispredict),   32'(e_mis));
        chk("redirect_pc",     redirect_pc,       e_red);
        chk("bht_is_write",    32'(bht_is_write), 32'(e_bw));
        chk("bht_executed_pc", bht_executed_pc,   e_bpc);
        chk("bht_dest_pc",     bht_dest_pc,       e_bdst);
        chk("bht_is_taken",    32'(bht_is_taken), 32'(e_btk));
        chk("underflow",       32'(underflow),    32'(e_und));
        chk("count",           32'(count),        e_cnt);
        if (verbose)
            $display("txn rst=%0b fl=%0b enq=%0b pc=%h res=%0b tk=%0b tgt=%h -> cnt=%0d bw=%0b xpc=%h mis=%0b rpc=%h uf=%0b",
                     r, f, ev, epc, rv, rt, rtg, count, bht_is_write, bht_executed_pc,
                     mispredict, redirect_pc, underflow);
    endtask

    task automatic enq(input logic [31:0] pc, input logic pt, input logic [31:0] ppc);
        cyc(0, 0, 1, pc, pt, ppc, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic r, f, ev, ept, rv, rt;
        logic [31:0] epc, eppc, rtg;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset enq_ready", 32'(enq_ready), 32'd1);

        // Correct taken prediction
        enq(32'h1000, 1, 32'h1040);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 32'h1040);
        chk("d1 bht_is_write", 32'(bht_is_write), 32'd1);
        chk("d1 executed_pc", bht_executed_pc, 32'h1000);
        chk("d1 dest_pc", bht_dest_pc, 32'h1040);
        chk("d1 mispredict", 32'(mispredict), 32'd0);
        chk("d1 count", 32'(count), 32'd0);
        idle();
        chk("d1 pulse end", 32'(bht_is_write), 32'd0);

        // Wrong direction: redirect to delay-slot fall-through, squash, same-cycle enqueue dropped
        enq(32'h2000, 1, 32'h2100);
        enq(32'h2010, 0, 32'h0);
        enq(32'h2020, 0, 32'h0);
        chk("d2 count3", 32'(count), 32'd3);
        cyc(0, 0, 1, 32'h2030, 0, 0, 1, 0, 32'h0);
        chk("d2 mispredict", 32'(mispredict), 32'd1);
        chk("d2 redirect", redirect_pc, 32'h2008);
        chk("d2 count", 32'(count), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 32'h1234);
        chk("d2 underflow", 32'(underflow), 32'd1);
        chk("d2 no bht", 32'(bht_is_write), 32'd0);

        // Full queue rejects enqueue, even alongside a pop
        for (int i = 0; i < 4; i++) enq(32'h5000 + 32'(4 * i), 0, 0);
        chk("d3 full ready", 32'(enq_ready), 32'd0);
        enq(32'h5100, 0, 0);
        chk("d3 count full", 32'(count), 32'd4);
        cyc(0, 0, 1, 32'h5200, 0, 0, 1, 0, 32'h0);
        chk("d3 count after pop", 32'(count), 32'd3);
        chk("d3 executed_pc", bht_executed_pc, 32'h5000);

        // Steady state pop+push with pointer wrap, FIFO order
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 32'h6000 + 32'(4 * i), 0, 0, 1, 0, 32'h0);
            chk("d4 count", 32'(count), 32'd3);
            chk("d4 order", bht_executed_pc,
                (i < 3) ? 32'h5004 + 32'(4 * i) : 32'h6000 + 32'(4 * (i - 3)));
        end

        // Flush beats resolution and enqueue
        cyc(0, 1, 1, 32'h7000, 0, 0, 1, 1, 32'h9999);
        chk("d5 count", 32'(count), 32'd0);
        chk("d5 mispredict", 32'(mispredict), 32'd0);
        chk("d5 bht", 32'(bht_is_write), 32'd0);

        // Reset mid-operation
        enq(32'h8000, 1, 32'h8800);
        enq(32'h8004, 0, 32'h0);
        cyc(1, 0, 1, 32'h8008, 0, 0, 1, 0, 32'h0);
        chk("d6 bht", 32'(bht_is_write), 32'd0);
        chk("d6 mispredict", 32'(mispredict), 32'd0);
        chk("d6 count", 32'(count), 32'd0);
        chk("d6 enq_ready", 32'(enq_ready), 32'd1);

        verbose = 0;
        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom_range(0, 99) == 0);
            f    = ($urandom_range(0, 99) < 3);
            ev   = ($urandom_range(0, 99) < 60);
            epc  = 32'h4000 + 32'($urandom_range(0, 255) * 4);
            ept  = 1'($urandom_range(0, 1));
            eppc = 32'h8000 + 32'($urandom_range(0, 3) * 16);
            rv   = ($urandom_range(0, 99) < 45);
            if (q.size() > 0 && $urandom_range(0, 1) == 0) begin
                rt  = q[0].pt;
                rtg = q[0].pt ? q[0].ppc : 32'($urandom);
            end else begin
                rt  = 1'($urandom_range(0, 1));
                rtg = 32'h8000 + 32'($urandom_range(0, 3) * 16);
            end
            cyc(r, f, ev, epc, ept, eppc, rv, rt, rtg);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bp_check_queue.md
BP_CHECK_QUEUE -- requirements
Module: bp_check_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of in-flight prediction entries (power of 2, at least 2).
REQ-002 SHALL have port clk  input  1  system clock, with all state updating on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush  input  1  pipeline flush request from exception or ERET logic.
REQ-005 SHALL have port enq_valid  input  1  fetch presents a predicted branch.
REQ-006 SHALL have port enq_ready  output  1  the queue accepts an entry this cycle.
REQ-007 SHALL have port enq_pc  input  32  PC of the branch being predicted.
REQ-008 SHALL have port enq_pred_taken  input  1  predicted direction (hit AND counter MSB).
REQ-009 SHALL have port enq_pred_pc  input  32  predicted target.
REQ-010 SHALL have port res_valid  input  1  execute resolves the oldest outstanding branch.
REQ-011 SHALL have port res_taken  input  1  actual direction.
REQ-012 SHALL have port res_target  input  32  actual taken target.
REQ-013 SHALL have port mispredict  output  1  one-cycle redirect pulse.
REQ-014 SHALL have port redirect_pc  output  32  correct next fetch PC.
REQ-015 SHALL have port bht_is_write  output  1  BHT update strobe.
REQ-016 SHALL have port bht_executed_pc  output  32  PC of the resolved branch.
REQ-017 SHALL have port bht_dest_pc  output  32  resolved target.
REQ-018 SHALL have port bht_is_taken  output  1  resolved direction.
REQ-019 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-020 SHALL have port underflow  output  1  one-cycle pulse when res_valid arrives while the queue is empty.

Function
REQ-021 SHALL be a circular FIFO with head and tail pointers of width $clog2(DEPTH), wrapping modulo DEPTH; each entry holds {pc, pred_taken, pred_pc}.
REQ-022 SHALL drive enq_ready = (count != DEPTH), combinationally; a pop in the same cycle SHALL NOT free a slot for that cycle's enqueue.
REQ-023 SHALL write the entry at tail and increment tail on enq_valid && enq_ready.
REQ-024 SHALL, on res_valid with count != 0, read the head entry, increment head, and evaluate wrong = (pred_taken != res_taken) || (res_taken && pred_pc != res_target).
REQ-025 SHALL register every resolution output: these outputs appear exactly 1 cycle after the res_valid cycle and are held at 0 in all other cycles (pulses).
REQ-026 SHALL drive bht_is_write=1, bht_executed_pc=head.pc, bht_dest_pc=res_target and bht_is_taken=res_taken for every valid resolution, whether correct or wrong.
REQ-027 SHALL, when wrong, pulse mispredict=1 with redirect_pc = res_taken ? res_target : head.pc+8 (delay slot, 32-bit wrap), and redirect_pc SHALL be 0 when mispredict=0.
REQ-028 SHALL, when wrong, discard all younger entries: at the next edge head=tail=0 and count=0, and any enqueue in the same cycle SHALL be dropped.
REQ-029 SHALL, on simultaneous correct resolution and accepted enqueue, leave count unchanged while both pointers advance.
REQ-030 SHALL, on res_valid with count==0, change no state, assert no bht or mispredict outputs, and pulse underflow the next cycle.
REQ-031 SHALL give flush highest priority: pointers and count go to 0, and a same-cycle enqueue, resolution, mispredict, bht update and underflow are all suppressed.
REQ-032 SHALL keep count within 0..DEPTH at all times, with count==DEPTH meaning full and 0 meaning empty.

Reset
REQ-033 SHALL, while reset=1 at a rising edge, clear head, tail and count and all registered outputs to 0; enq_ready SHALL read 1 in the following cycle.
REQ-034 SHALL give reset priority over flush, enqueue and resolution; entry storage need not be cleared.
REQ-035 SHALL, when reset is asserted mid-operation, discard all pending entries and SHALL NOT let a resolution in the reset cycle produce any output.

Verification
REQ-036 SHALL cover: enqueue pc=0x1000, pred_taken=1, pred_pc=0x1040; then resolve taken with target 0x1040 -> next cycle bht_is_write=1, executed_pc=0x1000, dest=0x1040, mispredict=0, count=0.
REQ-037 SHALL cover: enqueue pc=0x2000, pred_taken=1, then 0x2010 and 0x2020; resolve not-taken -> next cycle mispredict=1, redirect_pc=0x2008, count=0, and a later resolution gives underflow=1.
REQ-038 SHALL cover: fill DEPTH=4 -> enq_ready=0 and a fifth enqueue is ignored; resolve and enqueue in the same cycle -> the enqueue is still rejected and count=3.
REQ-039 SHALL cover: with 3 entries, correct resolution plus enqueue in the same cycle -> count stays 3; repeat for more than 8 cycles to exercise pointer wrap, checking FIFO order.
REQ-040 SHALL cover: flush asserted together with res_valid and enq_valid -> count=0, with no mispredict and no bht_is_write the next cycle.
REQ-041 SHALL cover: reset asserted with 2 entries and res_valid high -> all outputs 0, count=0, enq_ready=1.
